vga_timing: RTL and testbench

//  Free-running VGA raster timing generator; first stage of the top_vga pipeline.

---
 rtl/vga_timing.sv | 167 ++++++++++++++++
 tb/tb_vga_timing.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// vga_timing -- free-running VGA raster timing generator.
//
// Produces the pixel/line counters and the sync/blanking flags for one raster.
// Every output comes straight from a flop, and the flags are decoded from the
// counter values being loaded in the same edge. This means hcount/vcount and
// hsync/vsync/hblnk/vblnk always describe the same pixel, with no skew between
// them. rgb is a constant black background that later stages draw onto.
//
// Ports:
//   clk          in   pixel clock
//   rst_n        in   asynchronous reset, active-low
//   ce           in   pixel enable; the raster advances only when ce=1
//   hcount[10:0] out  current pixel within the line
//   vcount[10:0] out  current line within the frame
//   hsync, vsync out  sync pulses, active level set by SYNC_POL
//   hblnk, vblnk out  blanking flags (outside the visible area)
//   rgb[11:0]    out  constant 12'h000
//   frame_start  out  (VGA_TIMING_FRAME_EN) 1-cycle pulse when the raster wraps to (0,0)
//   frame_cnt    out  (VGA_TIMING_FRAME_EN) completed-frame counter, 16-bit wrapping
//
// Build option: define VGA_TIMING_FRAME_EN to add the frame_start/frame_cnt ports.
// Without it, no frame logic is built and the raster behaves identically.
`timescale 1ns/1ps

module vga_timing #(
   parameter int H_ACTIVE = 800,
   parameter int H_FRONT  = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BACK   = 88,
   parameter int V_ACTIVE = 600,
   parameter int V_FRONT  = 1,
   parameter int V_SYNC   = 4,
   parameter int V_BACK   = 23,
   parameter int SYNC_POL = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ce,
   output logic [10:0] hcount,
   output logic [10:0] vcount,
   output logic        hsync,
   output logic        vsync,
   output logic        hblnk,
   output logic        vblnk,
   output logic [11:0] rgb
`ifdef VGA_TIMING_FRAME_EN
   ,
   output logic        frame_start,
   output logic [15:0] frame_cnt
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FRONT);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FRONT);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic        SYNC_ON  = (SYNC_POL != 0);

   // Parameter sanity checks, evaluated at elaboration.
   if (H_TOTAL > 2047) begin : g_h_total_err
      $error("vga_timing: H_TOTAL exceeds 2047");
   end
   if (V_TOTAL > 2047) begin : g_v_total_err
      $error("vga_timing: V_TOTAL exceeds 2047");
   end
   if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1) begin : g_h_width_err
      $error("vga_timing: horizontal porch/sync widths must be >= 1");
   end
   if (V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_v_width_err
      $error("vga_timing: vertical porch/sync widths must be >= 1");
   end

   logic [10:0] hcount_q, hcount_d;
   logic [10:0] vcount_q, vcount_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        hblnk_q, hblnk_d;
   logic        vblnk_q, vblnk_d;
   logic        line_end;
   logic        frame_end;

   assign line_end  = (hcount_q == H_LAST);
   assign frame_end = line_end && (vcount_q == V_LAST);

   always_comb begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      if (ce) begin
         if (line_end) begin
            hcount_d = '0;
            vcount_d = frame_end ? '0 : vcount_q + 11'd1;
         end else begin
            hcount_d = hcount_q + 11'd1;
         end
      end
      // Flags decode the counter values being loaded, so they land in the same
      // output cycle as the pixel they describe. When ce=0 the counters hold,
      // and so the decoded flags hold as well.
      hblnk_d = (hcount_d >= H_ACT);
      vblnk_d = (vcount_d >= V_ACT);
      hsync_d = (hcount_d >= HS_START && hcount_d < HS_END) ? SYNC_ON : ~SYNC_ON;
      vsync_d = (vcount_d >= VS_START && vcount_d < VS_END) ? SYNC_ON : ~SYNC_ON;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount_q <= '0;
         vcount_q <= '0;
         hsync_q  <= ~SYNC_ON;
         vsync_q  <= ~SYNC_ON;
         hblnk_q  <= 1'b0;
         vblnk_q  <= 1'b0;
      end else begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         hblnk_q  <= hblnk_d;
         vblnk_q  <= vblnk_d;
      end
   end

   assign hcount = hcount_q;
   assign vcount = vcount_q;
   assign hsync  = hsync_q;
   assign vsync  = vsync_q;
   assign hblnk  = hblnk_q;
   assign vblnk  = vblnk_q;
   assign rgb    = 12'h000;

`ifdef VGA_TIMING_FRAME_EN
   logic        frame_start_q, frame_start_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   // Pulse only on a genuine wrap out of the last pixel. The (0,0) state that
   // follows reset is not a frame boundary. The pulse lasts one clock even if
   // ce then drops.
   always_comb begin
      frame_start_d = ce && frame_end;
      frame_cnt_d   = frame_cnt_q;
      if (frame_start_d) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign frame_start = frame_start_q;
   assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
`timescale 1ns/1ps

module tb_vga_timing;

   // Small raster for fast frame-level checks: 25 x 11 = 275 pixels per frame.
   localparam int S_HA = 16, S_HF = 2, S_HS = 3, S_HB = 4;
   localparam int S_VA = 6,  S_VF = 1, S_VS = 2, S_VB = 2;
   localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
   localparam int S_FRAME = S_HT * (S_VA + S_VF + S_VS + S_VB);
   // Default 800x600 raster: 1056 x 628 pixels per frame.
   localparam int D_FRAME = 1056 * 628;

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } pix_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ce = 1'b0;

   logic [10:0] s_hc, s_vc, d_hc, d_vc, n_hc, n_vc;
   logic        s_hs, s_vs, s_hb, s_vb;
   logic        d_hs, d_vs, d_hb, d_vb;
   logic        n_hs, n_vs, n_hb, n_vb;
   logic [11:0] s_rgb, d_rgb, n_rgb;
`ifdef VGA_TIMING_FRAME_EN
   logic        s_fs, d_fs, n_fs;
   logic [15:0] s_fc, d_fc, n_fc;
`endif

   always #5 clk = ~clk;

   vga_timing #(.H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
                .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
                .SYNC_POL(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .ce(ce),
      .hcount(s_hc), .vcount(s_vc), .hsync(s_hs), .vsync(s_vs),
      .hblnk(s_hb), .vblnk(s_vb), .rgb(s_rgb)
`ifdef VGA_TIMING_FRAME_EN
      , .frame_start(s_fs), .frame_cnt(s_fc)
`endif
   );

   vga_timing dut_d (
      .clk(clk), .rst_n(rst_n), .ce(ce),
      .hcount(d_hc), .vcount(d_vc), .hsync(d_hs), .vsync(d_vs),
      .hblnk(d_hb), .vblnk(d_vb), .rgb(d_rgb)
`ifdef VGA_TIMING_FRAME_EN
      , .frame_start(d_fs), .frame_cnt(d_fc)
`endif
   );

   vga_timing #(.H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
                .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
                .SYNC_POL(0)) dut_n (
      .clk(clk), .rst_n(rst_n), .ce(ce),
      .hcount(n_hc), .vcount(n_vc), .hsync(n_hs), .vsync(n_vs),
      .hblnk(n_hb), .vblnk(n_vb), .rgb(n_rgb)
`ifdef VGA_TIMING_FRAME_EN
      , .frame_start(n_fs), .frame_cnt(n_fc)
`endif
   );

   int checks = 0;
   int failures = 0;

   // Model state: linear pixel index within the frame, plus frame bookkeeping.
   int p_s = 0, p_d = 0, fcnt = 0;
   bit fs_exp = 1'b0;

   // Measurements taken from the DUT outputs, compared against literals.
   int ce_since = 0, last_period = -1, n_wraps = 0, fs_pulses = 0;
   bit meas_line = 1'b0;
   int hs_cnt = 0, hb_cnt = 0, hs_first = -1, hs_last = -1;

   // Raster outputs for pixel index p, from the timing table alone.
   function automatic pix_t model(input int p, input int ha, input int hf, input int hsw,
                                  input int hbp, input int va, input int vf, input int vsw,
                                  input bit pol);
      pix_t m;
      int ht, h, v;
      ht = ha + hf + hsw + hbp;
      h = p % ht;
      v = p / ht;
      m.hcount = 11'(h);
      m.vcount = 11'(v);
      m.hblnk  = (h >= ha);
      m.vblnk  = (v >= va);
      m.hsync  = (h >= ha + hf && h < ha + hf + hsw) ? pol : ~pol;
      m.vsync  = (v >= va + vf && v < va + vf + vsw) ? pol : ~pol;
      m.rgb    = 12'h000;
      return m;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   task automatic compare_all();
      chk("raster_small", {s_hc, s_vc, s_hs, s_vs, s_hb, s_vb, s_rgb},
          model(p_s, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, 1'b1));
      chk("raster_default", {d_hc, d_vc, d_hs, d_vs, d_hb, d_vb, d_rgb},
          model(p_d, 800, 40, 128, 88, 600, 1, 4, 1'b1));
      chk("raster_neg_pol", {n_hc, n_vc, n_hs, n_vs, n_hb, n_vb, n_rgb},
          model(p_s, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, 1'b0));
`ifdef VGA_TIMING_FRAME_EN
      chk("frame_start", 64'(s_fs), 64'(fs_exp));
      chk("frame_cnt", 64'(s_fc), 64'(fcnt));
`endif
   endtask

   // One clock: drive ce, advance the model on the edge, compare on the falling edge.
   task automatic cyc(input logic ce_v);
      ce = ce_v;
      @(posedge clk);
      fs_exp = 1'b0;
      if (rst_n && ce_v) begin
         if (p_s == S_FRAME - 1) begin
            fs_exp = 1'b1;
            fcnt = (fcnt + 1) % 65536;
         end
         p_s = (p_s + 1) % S_FRAME;
         p_d = (p_d + 1) % D_FRAME;
      end
      @(negedge clk);
      compare_all();
      if (rst_n && ce_v) begin
         ce_since++;
         if (s_hc == 0 && s_vc == 0) begin
            last_period = ce_since;
            ce_since = 0;
            n_wraps++;
         end
      end
`ifdef VGA_TIMING_FRAME_EN
      if (s_fs) fs_pulses++;
`endif
      if (meas_line && d_vc == 0) begin
         if (d_hs) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(d_hc);
            hs_last = int'(d_hc);
         end
         if (d_hb) hb_cnt++;
      end
   endtask

   initial begin
      logic [15:0] ce_pat;
      ce_pat = 16'b1011_0111_0101_1101;

      // Reset held for 5 cycles.
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) cyc(1'b1);
      chk("reset_hcount", 64'(d_hc), 64'd0);
      chk("reset_hsync", 64'(d_hs), 64'd0);
      chk("reset_hsync_neg", 64'(n_hs), 64'd1);

      // Release, then the first enabled cycle shows hcount=1.
      rst_n = 1'b1;
      meas_line = 1'b1;
      cyc(1'b1);
      chk("first_hcount", 64'(d_hc), 64'd1);
      chk("first_vcount", 64'(d_vc), 64'd0);

      // Run the default raster to the end of line 0, then wrap.
      for (int i = 0; i < 2000 && p_d != 1055; i++) cyc(1'b1);
      chk("line_end_hcount", 64'(d_hc), 64'd1055);
      cyc(1'b1);
      meas_line = 1'b0;
      chk("line_wrap_hcount", 64'(d_hc), 64'd0);
      chk("line_wrap_vcount", 64'(d_vc), 64'd1);
      chk("hsync_width", 64'(hs_cnt), 64'd128);
      chk("hsync_first", 64'(hs_first), 64'd840);
      chk("hsync_last", 64'(hs_last), 64'd967);
      chk("hblnk_width", 64'(hb_cnt), 64'd256);
      chk("small_frame_period", 64'(last_period), 64'd275);

      // ce gating at hcount=10: pattern 1,0,0,1.
      for (int i = 0; i < 100 && (p_s % S_HT) != 10; i++) cyc(1'b1);
      chk("gate_at10", 64'(s_hc), 64'd10);
      cyc(1'b0);
      chk("gate_hold1", 64'(s_hc), 64'd10);
      cyc(1'b0);
      chk("gate_hold2", 64'(s_hc), 64'd10);
      cyc(1'b1);
      chk("gate_resume", 64'(s_hc), 64'd11);

      // Irregular ce: frame length in enabled cycles must be unchanged.
      last_period = -1;
      for (int i = 0; i < 700; i++) cyc(ce_pat[i % 16]);
      chk("gated_frame_period", 64'(last_period), 64'd275);

      // Mid-frame asynchronous reset while both syncs are active (hcount=20, vcount=7).
      for (int i = 0; i < 400 && p_s != 7 * S_HT + 20; i++) cyc(1'b1);
      chk("pre_reset_hsync", 64'(s_hs), 64'd1);
      chk("pre_reset_vsync", 64'(s_vs), 64'd1);
      #2;
      rst_n = 1'b0;
      p_s = 0;
      p_d = 0;
      fcnt = 0;
      fs_exp = 1'b0;
      ce_since = 0;
      n_wraps = 0;
      fs_pulses = 0;
      #1;
      chk("async_hsync", 64'(s_hs), 64'd0);
      chk("async_vsync", 64'(s_vs), 64'd0);
      chk("async_hcount", 64'(s_hc), 64'd0);
      chk("async_hsync_neg", 64'(n_hs), 64'd1);
      cyc(1'b1);
      cyc(1'b1);
      rst_n = 1'b1;
      cyc(1'b1);
      chk("restart_hcount", 64'(s_hc), 64'd1);
      chk("restart_vcount", 64'(s_vc), 64'd0);

      // Three full small frames after reset.
      for (int i = 1; i < 3 * S_FRAME; i++) cyc(1'b1);
      chk("three_wraps", 64'(n_wraps), 64'd3);
      chk("three_frames_origin", 64'({s_hc, s_vc}), 64'd0);
`ifdef VGA_TIMING_FRAME_EN
      chk("frame_cnt_3", 64'(s_fc), 64'd3);
      chk("frame_pulses_3", 64'(fs_pulses), 64'd3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
